fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the RISC-V core. It holds the PC, addresses the combinational instruction ROM, and registers the fetched word. It also slices out the funct7, funct3 and 5-bit op_code fields that the downstream decode controller consumes. It handles stall, redirect/flush (branch, jal, jalr) and ecall halt, and keeps cycle and retired-fetch counters for the board display.

---
 rtl/fetch_stage.sv | 71 +++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register, stall/redirect/halt control and counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [6:0]         funct7,
  output logic [2:0]         funct3,
  output logic [4:0]         op_code,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic               halted,
  output logic [31:0]        cycle_count,
  output logic [31:0]        fetch_count
);

  assign imem_addr = pc[IMEM_AW+1:2];

  assign if_id_pc4 = if_id_pc + 32'd4;
  assign funct7    = if_id_instr[31:25];
  assign funct3    = if_id_instr[14:12];
  assign op_code   = if_id_instr[6:2];
  assign rs1       = if_id_instr[19:15];
  assign rs2       = if_id_instr[24:20];
  assign rd        = if_id_instr[11:7];

  // if_id_pc is left untouched on bubbles so it does not toggle needlessly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      halted      <= 1'b0;
      cycle_count <= 32'd0;
      fetch_count <= 32'd0;
    end else if (!halted) begin
      cycle_count <= cycle_count + 32'd1;
      if (halt) begin
        halted      <= 1'b1;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (redirect) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        if_id_instr <= imem_rdata;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
        pc          <= pc + 32'd4;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  op_code;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;

  logic [31:0] rom [0:1023];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc(pc), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .funct7(funct7), .funct3(funct3), .op_code(op_code), .rs1(rs1),
    .rs2(rs2), .rd(rd), .halted(halted), .cycle_count(cycle_count),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " imem_addr"}, {22'd0, imem_addr}, 32'h0);
    check({tag, " instr"}, if_id_instr, 32'h0000_0013);
    check({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, " if_id_pc"}, if_id_pc, 32'h0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " cycle_count"}, cycle_count, 32'd0);
    check({tag, " fetch_count"}, fetch_count, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0010_0093 + i;
    rom[17] = 32'h00B5_0533;

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    step();
    check_reset_state("reset");

    // free run: 4 fetches
    rst_n = 1'b1;
    step();
    check("run1 pc", pc, 32'd4);
    check("run1 instr", if_id_instr, 32'h0010_0093);
    check("run1 valid", {31'd0, if_id_valid}, 32'd1);
    check("run1 if_id_pc", if_id_pc, 32'd0);
    step(); step(); step();
    check("run4 pc", pc, 32'd16);
    check("run4 instr", if_id_instr, 32'h0010_0096);
    check("run4 if_id_pc", if_id_pc, 32'd12);
    check("run4 if_id_pc4", if_id_pc4, 32'd16);
    check("run4 fetch_count", fetch_count, 32'd4);
    check("run4 cycle_count", cycle_count, 32'd4);

    // reset again, then stall at pc=8
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    check("pre-stall pc", pc, 32'd8);
    check("pre-stall instr", if_id_instr, 32'h0010_0094);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall pc", pc, 32'd8);
      check("stall instr", if_id_instr, 32'h0010_0094);
    end
    check("stall cycle_count", cycle_count, 32'd4);
    check("stall fetch_count", fetch_count, 32'd2);
    stall = 1'b0;
    step();
    check("resume pc", pc, 32'd12);
    check("resume instr", if_id_instr, 32'h0010_0095);
    check("resume if_id_pc", if_id_pc, 32'd8);

    // redirect with simultaneous stall; misaligned target
    redirect = 1'b1; redirect_pc = 32'h0000_0042; stall = 1'b1;
    step();
    check("redir pc", pc, 32'h40);
    check("redir valid", {31'd0, if_id_valid}, 32'd0);
    check("redir instr", if_id_instr, 32'h0000_0013);
    check("redir if_id_pc hold", if_id_pc, 32'd8);
    check("redir cycle_count", cycle_count, 32'd6);
    check("redir fetch_count", fetch_count, 32'd3);
    redirect = 1'b0; stall = 1'b0;
    step();
    check("post-redir instr", if_id_instr, 32'h0010_00A3);
    check("post-redir if_id_pc", if_id_pc, 32'h40);
    check("post-redir if_id_pc4", if_id_pc4, 32'h44);
    check("post-redir valid", {31'd0, if_id_valid}, 32'd1);

    // add x10,x10,x11 decode fields
    step();
    check("add instr", if_id_instr, 32'h00B5_0533);
    check("add funct7", {25'd0, funct7}, 32'h00);
    check("add funct3", {29'd0, funct3}, 32'd0);
    check("add op_code", {27'd0, op_code}, 32'h0C);
    check("add rd", {27'd0, rd}, 32'd10);
    check("add rs1", {27'd0, rs1}, 32'd10);
    check("add rs2", {27'd0, rs2}, 32'd11);
    check("add pc", pc, 32'h48);
    check("add cycle_count", cycle_count, 32'd8);
    check("add fetch_count", fetch_count, 32'd5);

    // halt, then frozen despite input activity
    halt = 1'b1;
    step();
    check("halt halted", {31'd0, halted}, 32'd1);
    check("halt valid", {31'd0, if_id_valid}, 32'd0);
    check("halt instr", if_id_instr, 32'h0000_0013);
    check("halt pc", pc, 32'h48);
    check("halt cycle_count", cycle_count, 32'd9);
    check("halt fetch_count", fetch_count, 32'd5);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      redirect = i[0]; stall = i[1]; redirect_pc = 32'h100 + 32'(i * 4);
      step();
      check("frozen pc", pc, 32'h48);
      check("frozen cycle_count", cycle_count, 32'd9);
      check("frozen fetch_count", fetch_count, 32'd5);
      check("frozen halted", {31'd0, halted}, 32'd1);
    end
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b1; halt = 1'b1;
    step();
    check_reset_state("halt-reset");
    stall = 1'b0; halt = 1'b0;

    // pc wrap at top of address space
    rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    check("wrap pre pc", pc, 32'hFFFF_FFFC);
    check("wrap pre imem_addr", {22'd0, imem_addr}, 32'h3FF);
    redirect = 1'b0;
    step();
    check("wrap pc", pc, 32'h0);
    check("wrap imem_addr", {22'd0, imem_addr}, 32'h0);
    check("wrap instr", if_id_instr, 32'h0010_0492);
    check("wrap if_id_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap if_id_pc4", if_id_pc4, 32'h0);

    // halt wins over simultaneous redirect
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    check("halt-vs-redir pc", pc, 32'h0);
    check("halt-vs-redir halted", {31'd0, halted}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
